// File: rtl/uart_fifo_ctrl.sv
// rtl/uart_fifo_ctrl.sv - circular byte FIFO sequencer for the 512x8 UART RAM
// Push side writes RAM directly; pop side fetches through a 1-cycle RAM read into a valid/ready register.
module uart_fifo_ctrl #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_clear,
  input  logic              i_push,
  input  logic [DATA_W-1:0] i_push_data,
  output logic              o_full,
  output logic              o_overflow,
  output logic              o_rd_valid,
  output logic [DATA_W-1:0] o_rd_data,
  input  logic              i_rd_ready,
  output logic              o_empty,
  output logic [ADDR_W:0]   o_count,
  output logic [ADDR_W-1:0] ram_read_addr,
  input  logic [DATA_W-1:0] ram_read_data,
  output logic [ADDR_W-1:0] ram_write_addr,
  output logic [DATA_W-1:0] ram_write_data,
  output logic              ram_write_strobe
);

  localparam logic [ADDR_W:0]   FULL_CNT = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_HAVE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]     ram_count_q, ram_count_d;
  logic                rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;
  logic                overflow_q, overflow_d;
  logic                push_acc;
  logic                fetch;

  // Full looks only at committed RAM occupancy, so a slot freed by this cycle's fetch is not reusable yet.
  assign o_full   = (ram_count_q == FULL_CNT);
  assign push_acc = i_push & ~o_full & ~i_clear;
  assign fetch    = (state_q == S_FETCH) & ~i_clear;

  always_comb begin
    state_d     = state_q;
    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ram_count_d = ram_count_q;
    rd_valid_d  = rd_valid_q;
    rd_data_d   = rd_data_q;
    overflow_d  = overflow_q | (i_push & o_full);

    if (push_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;

    case ({push_acc, fetch})
      2'b10:   ram_count_d = ram_count_q + CNT_ONE;
      2'b01:   ram_count_d = ram_count_q - CNT_ONE;
      default: ram_count_d = ram_count_q;
    endcase

    case (state_q)
      S_IDLE: begin
        if (ram_count_q != '0) state_d = S_FETCH;
      end
      S_FETCH: begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
        state_d  = S_WAIT;
      end
      S_WAIT: begin
        rd_data_d  = ram_read_data;
        rd_valid_d = 1'b1;
        state_d    = S_HAVE;
      end
      S_HAVE: begin
        if (i_rd_ready) begin
          rd_valid_d = 1'b0;
          state_d    = (ram_count_q != '0) ? S_FETCH : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // Flush drops the in-flight RAM read; the output register keeps its old byte but is marked invalid.
    if (i_clear) begin
      state_d     = S_IDLE;
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      ram_count_d = '0;
      overflow_d  = 1'b0;
      rd_valid_d  = 1'b0;
      rd_data_d   = rd_data_q;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_count_q <= '0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_count_q <= ram_count_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      overflow_q  <= overflow_d;
    end
  end

  assign o_count = ram_count_q
                 + {{ADDR_W{1'b0}}, (state_q == S_WAIT)}
                 + {{ADDR_W{1'b0}}, rd_valid_q};
  assign o_empty          = (o_count == '0);
  assign o_rd_valid       = rd_valid_q;
  assign o_rd_data        = rd_data_q;
  assign o_overflow       = overflow_q;
  assign ram_read_addr    = rd_ptr_q;
  assign ram_write_addr   = wr_ptr_q;
  assign ram_write_data   = i_push_data;
  assign ram_write_strobe = push_acc;

endmodule

// File: tb/tb_uart_fifo_ctrl.sv
// tb/tb_uart_fifo_ctrl.sv - self-checking bench for uart_fifo_ctrl with a 512x8 registered-read RAM model
module tb_uart_fifo_ctrl;

  logic       clk = 1'b0;
  logic       i_rst_n, i_clear, i_push, i_rd_ready;
  logic [7:0] i_push_data;
  logic       o_full, o_overflow, o_rd_valid, o_empty;
  logic [7:0] o_rd_data;
  logic [9:0] o_count;
  logic [8:0] ram_read_addr, ram_write_addr;
  logic [7:0] ram_read_data, ram_write_data;
  logic       ram_write_strobe;

  logic [7:0] mem [512];
  logic [7:0] q [$];
  logic [8:0] exp_waddr;
  int         n_vec = 0;
  int         n_err = 0;
  int         popped = 0;

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (ram_write_strobe) mem[ram_write_addr] <= ram_write_data;
    ram_read_data <= mem[ram_read_addr];
  end

  uart_fifo_ctrl #(.ADDR_W(9), .DATA_W(8)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_clear(i_clear),
    .i_push(i_push), .i_push_data(i_push_data),
    .o_full(o_full), .o_overflow(o_overflow),
    .o_rd_valid(o_rd_valid), .o_rd_data(o_rd_data), .i_rd_ready(i_rd_ready),
    .o_empty(o_empty), .o_count(o_count),
    .ram_read_addr(ram_read_addr), .ram_read_data(ram_read_data),
    .ram_write_addr(ram_write_addr), .ram_write_data(ram_write_data),
    .ram_write_strobe(ram_write_strobe)
  );

  typedef struct {
    logic       push;
    logic [7:0] data;
    logic       ready;
    logic       e_strobe;
    logic       e_valid;
    logic [7:0] e_data;
    int         e_count;
    logic       e_empty;
  } vec_t;

  vec_t tv [6];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    end
  endtask

  // One clock: drive at posedge+1, check at negedge, return at next posedge+1.
  task automatic step(input logic p, input logic [7:0] d, input logic r, input logic acc);
    logic [7:0] e;
    i_push = p; i_push_data = d; i_rd_ready = r;
    @(negedge clk);
    if (p) begin
      chk("push_strobe", 32'(ram_write_strobe), 32'(acc));
      if (acc) begin
        chk("push_waddr", 32'(ram_write_addr), 32'(exp_waddr));
        q.push_back(d);
        exp_waddr = exp_waddr + 9'd1;
      end
    end
    if (o_rd_valid && r) begin
      if (q.size() == 0) chk("pop_unexpected", 32'(1), 32'(0));
      else begin
        e = q.pop_front();
        chk("pop_data", 32'(o_rd_data), 32'(e));
        popped++;
      end
    end
    @(posedge clk); #1;
    i_push = 1'b0; i_rd_ready = 1'b0;
  endtask

  task automatic do_clear();
    i_clear = 1'b1; i_push = 1'b0; i_rd_ready = 1'b0;
    @(posedge clk); #1;
    i_clear = 1'b0;
    q.delete();
    exp_waddr = 9'd0;
  endtask

  task automatic drain(input string nm);
    for (int k = 0; k < 5000 && q.size() > 0; k++) step(1'b0, 8'h00, 1'b1, 1'b0);
    chk(nm, 32'(q.size()), 32'(0));
  endtask

  task automatic wait_valid(input string nm);
    for (int k = 0; k < 10 && !o_rd_valid; k++) step(1'b0, 8'h00, 1'b0, 1'b0);
    chk(nm, 32'(o_rd_valid), 32'(1));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    logic       p, r;
    logic [7:0] d;
    int         sent;

    i_rst_n = 1'b0; i_clear = 1'b0; i_push = 1'b0; i_push_data = 8'h00; i_rd_ready = 1'b0;
    exp_waddr = 9'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_count", 32'(o_count), 32'(0));
    chk("rst_empty", 32'(o_empty), 32'(1));
    chk("rst_full", 32'(o_full), 32'(0));
    chk("rst_valid", 32'(o_rd_valid), 32'(0));
    chk("rst_overflow", 32'(o_overflow), 32'(0));
    chk("rst_raddr", 32'(ram_read_addr), 32'(0));
    @(posedge clk); #1;
    i_rst_n = 1'b1;

    // Single byte: valid appears three edges after the push edge.
    tv[0] = '{1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1};
    tv[1] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1, 1'b0};
    tv[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1, 1'b0};
    tv[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1, 1'b0};
    tv[4] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'hA5, 1, 1'b0};
    tv[5] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 0, 1'b1};
    for (int i = 0; i < 6; i++) begin
      i_push = tv[i].push; i_push_data = tv[i].data; i_rd_ready = tv[i].ready;
      @(negedge clk);
      chk("t1_strobe", 32'(ram_write_strobe), 32'(tv[i].e_strobe));
      if (tv[i].e_strobe) begin
        chk("t1_waddr", 32'(ram_write_addr), 32'(exp_waddr));
        exp_waddr = exp_waddr + 9'd1;
      end
      chk("t1_valid", 32'(o_rd_valid), 32'(tv[i].e_valid));
      if (tv[i].e_valid) chk("t1_data", 32'(o_rd_data), 32'(tv[i].e_data));
      chk("t1_count", 32'(o_count), 32'(tv[i].e_count));
      chk("t1_empty", 32'(o_empty), 32'(tv[i].e_empty));
      @(posedge clk); #1;
    end

    // Fill to 513 with the consumer stalled, then one rejected push.
    for (int i = 0; i < 513; i++) step(1'b1, 8'(i), 1'b0, 1'b1);
    step(1'b1, 8'hEE, 1'b0, 1'b0);
    chk("t2_full", 32'(o_full), 32'(1));
    chk("t2_count", 32'(o_count), 32'(513));
    chk("t2_overflow", 32'(o_overflow), 32'(1));
    chk("t2_data_head", 32'(o_rd_data), 32'(0));
    drain("t2_drain");
    chk("t2_empty", 32'(o_empty), 32'(1));
    chk("t2_overflow_sticky", 32'(o_overflow), 32'(1));
    do_clear();
    chk("t2_clear_overflow", 32'(o_overflow), 32'(0));

    // Random push/ready gaps over more than one pointer wrap.
    sent = 0; popped = 0;
    for (int cyc = 0; cyc < 20000 && (sent < 600 || q.size() > 0); cyc++) begin
      p = (sent < 600) && ($urandom_range(0, 99) < 60) && ((sent - popped) < 500);
      r = ($urandom_range(0, 99) < 50);
      d = 8'($urandom_range(0, 255));
      step(p, d, r, p);
      if (p) sent++;
    end
    chk("t3_sent", 32'(sent), 32'(600));
    chk("t3_remaining", 32'(q.size()), 32'(0));
    chk("t3_overflow", 32'(o_overflow), 32'(0));

    // Push at the pop rate while popping; occupancy must stay small.
    for (int k = 0; k < 90; k++) begin
      p = ((k % 3) == 0);
      step(p, 8'(k * 7), 1'b1, p);
      chk("t4_count_bound", 32'(o_count <= 10'd3), 32'(1));
    end
    drain("t4_drain");

    // Clear during WAIT with five bytes queued.
    do_clear();
    for (int i = 0; i < 6; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b1);
    wait_valid("t5_have");
    chk("t5_count6", 32'(o_count), 32'(6));
    step(1'b0, 8'h00, 1'b1, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0);
    i_clear = 1'b1;
    @(negedge clk);
    chk("t5_count_wait", 32'(o_count), 32'(5));
    @(posedge clk); #1;
    i_clear = 1'b0;
    q.delete(); exp_waddr = 9'd0;
    chk("t5_valid", 32'(o_rd_valid), 32'(0));
    chk("t5_count", 32'(o_count), 32'(0));
    chk("t5_overflow", 32'(o_overflow), 32'(0));
    repeat (4) step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t5_no_ghost", 32'(o_rd_valid), 32'(0));
    step(1'b1, 8'h3C, 1'b0, 1'b1);
    wait_valid("t5_refill");
    step(1'b0, 8'h00, 1'b1, 1'b0);
    chk("t5_empty", 32'(o_empty), 32'(1));

    // Async reset while holding a byte.
    do_clear();
    step(1'b1, 8'h5A, 1'b0, 1'b1);
    wait_valid("t6_have");
    @(negedge clk);
    i_rst_n = 1'b0;
    #1;
    chk("t6_valid", 32'(o_rd_valid), 32'(0));
    chk("t6_data", 32'(o_rd_data), 32'(0));
    chk("t6_count", 32'(o_count), 32'(0));
    chk("t6_empty", 32'(o_empty), 32'(1));
    chk("t6_full", 32'(o_full), 32'(0));
    @(posedge clk); #1;
    i_rst_n = 1'b1;
    q.delete(); exp_waddr = 9'd0;
    repeat (4) step(1'b0, 8'h00, 1'b0, 1'b0);
    chk("t6_unreachable", 32'(o_count), 32'(0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
